// File: rtl/regfile_mp.sv
// Multi-read-port register file with sequenced zero-initialisation, optional x0 hardwiring
// and optional write-to-read bypass. Storage has no reset so it can map onto RAM.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int N_RD     = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_clear,
    input  logic                   i_we,
    input  logic [ADDR_W-1:0]      i_waddr,
    input  logic [DATA_W-1:0]      i_wdata,
    input  logic [N_RD*ADDR_W-1:0] i_raddr,
    output logic [N_RD*DATA_W-1:0] o_rdata,
    output logic                   o_ready
);
    localparam int                DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                wr_acc;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;

    // o_ready qualifies both sides: reads are valid and a write with i_we high is
    // taken at the edge only while o_ready is high and no clear is requested.
    assign o_ready = (state_q == ST_RUN);
    assign wr_acc  = o_ready && i_we && !i_clear &&
                     !((ZERO_REG != 0) && (i_waddr == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                if (i_clear) begin
                    cnt_d = '0;
                end else if (cnt_q == LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (i_clear) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // Single storage write port shared by the init sequencer and writeback.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = i_waddr;
        mem_wdata = i_wdata;
        if (state_q == ST_INIT) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wdata = '0;
        end else if (wr_acc) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    for (genvar k = 0; k < N_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] raddr;
        logic [DATA_W-1:0] rd;

        assign raddr = i_raddr[k*ADDR_W +: ADDR_W];

        always_comb begin
            rd = mem_q[raddr];
            if (!o_ready) begin
                rd = '0;
            end else if ((ZERO_REG != 0) && (raddr == '0)) begin
                rd = '0;
            end else if ((BYPASS != 0) && wr_acc && (raddr == i_waddr)) begin
                rd = i_wdata;
            end
        end

        assign o_rdata[k*DATA_W +: DATA_W] = rd;
    end
endmodule
